alu_frame_serializer: RTL and testbench

Parametrised result serializer for the ALU output path. Accepts one result packet (N data bytes plus a control byte, or a control byte alone for error responses) per valid/ready handshake and shifts it out on a single line as UART-style 11-bit frames. It sits between the ALU core and the serial output pin. Compared with the fixed 4-byte serializer, it generalises data width, adds flow control and a programmable inter-packet gap, and offers optional frame parity.

---
 rtl/alu_frame_serializer_if.sv | 27 ++
 rtl/alu_frame_serializer.sv | 153 +++++++++++++++
 tb/tb_alu_frame_serializer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_frame_serializer_if.sv
// Packet handshake bundle between the ALU core and the frame serializer.
// Ports: data_in, ctl_in, err_in, in_valid (core side drives), in_ready (serializer drives).
interface alu_frame_serializer_if #(
    parameter int DATA_BYTES = 4
);
    logic [8*DATA_BYTES-1:0] data_in;
    logic [7:0]              ctl_in;
    logic                    err_in;
    logic                    in_valid;
    logic                    in_ready;

    modport master (
        output data_in,
        output ctl_in,
        output err_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  data_in,
        input  ctl_in,
        input  err_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/alu_frame_serializer.sv
// ALU result serializer: one packet per handshake, sent as UART-style frames
// (start, type, 8 payload bits MSB first, [parity], stop), one bit per clk.
// Ports: clk, reset (async, active-low), bus (slave: data_in, ctl_in, err_in,
// in_valid, in_ready), sout (registered serial line, idles high), busy.
// Optional feature: define SER_PARITY_EN to add an even-parity bit per frame.
module alu_frame_serializer #(
    parameter int DATA_BYTES = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_frame_serializer_if.slave bus,
    output logic                  sout,
    output logic                  busy
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam int GW = $clog2(GAP_BITS + 1);

    localparam logic [BW-1:0] CTL_IDX  = BW'(DATA_BYTES);
    localparam logic [BW-1:0] BYTE_ONE = BW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_BITS - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_TYPE  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
`ifdef SER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd6;
`endif

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] data_q;
    logic [7:0]    ctl_q;
    logic          err_q;
    logic          sout_q;

    logic          is_ctl;
    logic [7:0]    cur_byte;
    logic [2:0]    bit_nxt;

    // The control frame is the last frame; error packets have only that one.
    assign is_ctl   = err_q || (byte_cnt == CTL_IDX);

    // data_q is shifted left after each data frame, so the next byte to
    // send is always in the top lane.
    assign cur_byte = is_ctl ? ctl_q : data_q[DW-1 -: 8];
    assign bit_nxt  = bit_cnt - 3'd1;

    assign bus.in_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign sout         = sout_q;

    // sout_q holds the line value for the state being entered, so the
    // line comes straight from a flop and the start bit follows the
    // accepting edge with no extra cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            data_q   <= '0;
            ctl_q    <= '0;
            err_q    <= 1'b0;
            sout_q   <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        data_q   <= bus.data_in;
                        ctl_q    <= bus.ctl_in;
                        err_q    <= bus.err_in;
                        byte_cnt <= bus.err_in ? CTL_IDX : '0;
                        bit_cnt  <= 3'd7;
                        gap_cnt  <= '0;
                        state    <= S_START;
                        sout_q   <= 1'b0;
                    end else begin
                        sout_q   <= 1'b1;
                    end
                end
                S_START: begin
                    bit_cnt <= 3'd7;
                    state   <= S_TYPE;
                    sout_q  <= is_ctl;
                end
                S_TYPE: begin
                    state  <= S_DATA;
                    sout_q <= cur_byte[7];
                end
                S_DATA: begin
                    if (bit_cnt == 3'd0) begin
`ifdef SER_PARITY_EN
                        state  <= S_PARITY;
                        sout_q <= ^{is_ctl, cur_byte};
`else
                        state  <= S_STOP;
                        sout_q <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_nxt;
                        sout_q  <= cur_byte[bit_nxt];
                    end
                end
`ifdef SER_PARITY_EN
                S_PARITY: begin
                    state  <= S_STOP;
                    sout_q <= 1'b1;
                end
`endif
                S_STOP: begin
                    if (!is_ctl) begin
                        byte_cnt <= byte_cnt + BYTE_ONE;
                        data_q   <= data_q << 8;
                        bit_cnt  <= 3'd7;
                        state    <= S_START;
                        sout_q   <= 1'b0;
                    end else if (GAP_BITS == 1) begin
                        state  <= S_IDLE;
                        sout_q <= 1'b1;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                        sout_q  <= 1'b1;
                    end
                end
                S_GAP: begin
                    sout_q <= 1'b1;
                    // The IDLE cycle that follows is the last gap cycle.
                    if (gap_cnt <= GAP_ONE) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    sout_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_serializer.sv
// Self-checking bench for alu_frame_serializer: streams are compared with a
// queue-based frame model; builds with or without SER_PARITY_EN.
module tb_alu_frame_serializer;

`ifdef SER_PARITY_EN
    localparam int FL = 12;
    localparam logic [FL-1:0] FIRST_F = 12'b0_0_00010010_0_1;
    localparam logic [FL-1:0] LAST_F  = 12'b0_1_00101011_1_1;
    localparam logic [FL-1:0] ERR_F   = 12'b0_1_10010011_1_1;
`else
    localparam int FL = 11;
    localparam logic [FL-1:0] FIRST_F = 11'b0_0_00010010_1;
    localparam logic [FL-1:0] LAST_F  = 11'b0_1_00101011_1;
    localparam logic [FL-1:0] ERR_F   = 11'b0_1_10010011_1;
`endif
    localparam int NA    = 4;
    localparam int NB    = 2;
    localparam int GB    = 3;
    localparam int PKT_A = (NA + 1) * FL;
    localparam int PKT_B = (NB + 1) * FL;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sout_a, busy_a, sout_b, busy_b;

    always #5 clk = ~clk;

    alu_frame_serializer_if #(.DATA_BYTES(NA)) a_if ();
    alu_frame_serializer_if #(.DATA_BYTES(NB)) b_if ();

    alu_frame_serializer #(.DATA_BYTES(NA), .GAP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave),
        .sout(sout_a), .busy(busy_a)
    );

    alu_frame_serializer #(.DATA_BYTES(NB), .GAP_BITS(GB)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave),
        .sout(sout_b), .busy(busy_b)
    );

    int tests = 0;
    int fails = 0;
    int busy_cnt, rdy_cnt;
    logic exp_q[$];
    logic cap[$];

    function automatic void add_frame(input logic [7:0] b, input logic t);
        exp_q.push_back(1'b0);
        exp_q.push_back(t);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^{t, b});
`endif
        exp_q.push_back(1'b1);
    endfunction

    function automatic void add_pkt(input logic [63:0] d, input int n,
                                    input logic [7:0] c, input logic e);
        if (!e)
            for (int k = n - 1; k >= 0; k--) add_frame(d[8*k +: 8], 1'b0);
        add_frame(c, 1'b1);
    endfunction

    function automatic void add_ones(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        if (cap.size() != exp_q.size()) return 0;
        foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [FL-1:0] frame_at(input int k);
        logic [FL-1:0] v = '0;
        for (int i = 0; i < FL; i++) v = {v[FL-2:0], cap[k+i]};
        return v;
    endfunction

    task automatic wait_idle_a();
        int t = 0;
        @(negedge clk);
        while (a_if.in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (a_if.in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL idle_a_timeout: in_ready=%b want 1", a_if.in_ready);
        end
    endtask

    task automatic wait_idle_b();
        int t = 0;
        @(negedge clk);
        while (b_if.in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (b_if.in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL idle_b_timeout: in_ready=%b want 1", b_if.in_ready);
        end
    endtask

    // Called on a negedge with dut_a idle; captures n cycles of sout.
    task automatic launch_a(input logic [31:0] d, input logic [7:0] c,
                            input logic e, input int n);
        cap.delete();
        busy_cnt = 0;
        rdy_cnt  = 0;
        a_if.data_in  = d;
        a_if.ctl_in   = c;
        a_if.err_in   = e;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) a_if.in_valid = 1'b0;
            cap.push_back(sout_a);
            busy_cnt += int'(busy_a);
            rdy_cnt  += int'(a_if.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (sout_a !== 1'b1 || busy_a !== 1'b0 || a_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_held_a: sout=%b busy=%b rdy=%b want 1 0 1",
                     sout_a, busy_a, a_if.in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (sout_a !== 1'b1 || busy_a !== 1'b0 || a_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rel_a: sout=%b busy=%b rdy=%b want 1 0 1",
                     sout_a, busy_a, a_if.in_ready);
        end
        tests++;
        if (sout_b !== 1'b1 || busy_b !== 1'b0 || b_if.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rel_b: sout=%b busy=%b rdy=%b want 1 0 1",
                     sout_b, busy_b, b_if.in_ready);
        end
    endtask

    task automatic test_normal();
        int dd;
        wait_idle_a();
        exp_q.delete();
        add_pkt(64'h12345678, NA, 8'h2B, 1'b0);
        launch_a(32'h12345678, 8'h2B, 1'b0, PKT_A);
        dd = first_diff();
        tests++;
        if (dd != -1) begin
            fails++;
            $display("FAIL normal_stream: bit %0d got %b want %b",
                     dd, cap[dd], exp_q[dd]);
        end
        tests++;
        if (frame_at(0) !== FIRST_F) begin
            fails++;
            $display("FAIL normal_first: got %b want %b", frame_at(0), FIRST_F);
        end
        tests++;
        if (frame_at(PKT_A - FL) !== LAST_F) begin
            fails++;
            $display("FAIL normal_last: got %b want %b",
                     frame_at(PKT_A - FL), LAST_F);
        end
`ifdef SER_PARITY_EN
        tests++;
        if (cap[FL-2] !== 1'b0 || cap[PKT_A-2] !== 1'b1) begin
            fails++;
            $display("FAIL parity_bits: got %b %b want 0 1",
                     cap[FL-2], cap[PKT_A-2]);
        end
`endif
        tests++;
        if (busy_cnt != PKT_A || rdy_cnt != 0) begin
            fails++;
            $display("FAIL normal_busy: busy=%0d rdy=%0d want %0d 0",
                     busy_cnt, rdy_cnt, PKT_A);
        end
        @(negedge clk);
        tests++;
        if (a_if.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL normal_end: rdy=%b busy=%b want 1 0",
                     a_if.in_ready, busy_a);
        end
    endtask

    task automatic test_error();
        int dd;
        wait_idle_a();
        exp_q.delete();
        add_pkt(64'hFFFFFFFF, NA, 8'h93, 1'b1);
        add_ones(6);
        launch_a(32'hFFFFFFFF, 8'h93, 1'b1, FL + 6);
        dd = first_diff();
        tests++;
        if (dd != -1) begin
            fails++;
            $display("FAIL error_stream: bit %0d got %b want %b",
                     dd, cap[dd], exp_q[dd]);
        end
        tests++;
        if (frame_at(0) !== ERR_F) begin
            fails++;
            $display("FAIL error_frame: got %b want %b", frame_at(0), ERR_F);
        end
        tests++;
        if (busy_cnt != FL) begin
            fails++;
            $display("FAIL error_busy: got %0d want %0d", busy_cnt, FL);
        end
    endtask

    task automatic test_random();
        int dd, n;
        logic [31:0] d;
        logic [7:0] c;
        logic e;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            c = 8'($urandom);
            e = ($urandom_range(0, 3) == 0);
            n = e ? FL : PKT_A;
            wait_idle_a();
            exp_q.delete();
            add_pkt({32'h0, d}, NA, c, e);
            launch_a(d, c, e, n);
            dd = first_diff();
            tests++;
            if (dd != -1 || busy_cnt != n) begin
                fails++;
                $display("FAIL random_%0d: d=%h c=%h e=%b bit %0d got %b want %b busy %0d want %0d",
                         k, d, c, e, dd, cap[dd < 0 ? 0 : dd],
                         exp_q[dd < 0 ? 0 : dd], busy_cnt, n);
            end
        end
    endtask

    task automatic test_busy_protect();
        int dd;
        logic [31:0] d;
        logic [7:0] c;
        d = $urandom;
        c = 8'($urandom);
        wait_idle_a();
        exp_q.delete();
        add_pkt({32'h0, d}, NA, c, 1'b0);
        cap.delete();
        rdy_cnt = 0;
        a_if.data_in  = d;
        a_if.ctl_in   = c;
        a_if.err_in   = 1'b0;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < PKT_A; i++) begin
            @(negedge clk);
            if (i == 0) a_if.in_valid = 1'b0;
            if (i == 20) begin
                a_if.data_in  = ~d;
                a_if.ctl_in   = ~c;
                a_if.err_in   = 1'b1;
                a_if.in_valid = 1'b1;
            end
            if (i == 22) a_if.in_valid = 1'b0;
            cap.push_back(sout_a);
            rdy_cnt += int'(a_if.in_ready);
        end
        dd = first_diff();
        tests++;
        if (dd != -1) begin
            fails++;
            $display("FAIL busy_stream: bit %0d got %b want %b",
                     dd, cap[dd], exp_q[dd]);
        end
        tests++;
        if (rdy_cnt != 0) begin
            fails++;
            $display("FAIL busy_ready: in_ready high %0d cycles want 0", rdy_cnt);
        end
    endtask

    task automatic test_async_reset();
        int dd;
        logic [31:0] d;
        logic [7:0] c;
        wait_idle_a();
        // Frame 2 carries 0xC3; its third data bit is 0.
        launch_a(32'h12C34567, 8'h5A, 1'b0, FL + 5);
        tests++;
        if (cap[FL+4] !== 1'b0) begin
            fails++;
            $display("FAIL areset_pre: sout=%b want 0", cap[FL+4]);
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if (sout_a !== 1'b1 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL areset_async: sout=%b busy=%b want 1 0",
                     sout_a, busy_a);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (a_if.in_ready !== 1'b1 || sout_a !== 1'b1) begin
            fails++;
            $display("FAIL areset_release: rdy=%b sout=%b want 1 1",
                     a_if.in_ready, sout_a);
        end
        d = $urandom;
        c = 8'($urandom);
        @(negedge clk);
        exp_q.delete();
        add_pkt({32'h0, d}, NA, c, 1'b0);
        launch_a(d, c, 1'b0, PKT_A);
        dd = first_diff();
        tests++;
        if (dd != -1) begin
            fails++;
            $display("FAIL areset_next: bit %0d got %b want %b",
                     dd, cap[dd], exp_q[dd]);
        end
    endtask

    task automatic test_back_to_back();
        int dd, rdy, bsy, total;
        logic drop;
        logic [15:0] d1, d2;
        logic [7:0] c1, c2;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        c1 = 8'($urandom);
        c2 = 8'($urandom);
        total = 2 * PKT_B + GB;
        wait_idle_b();
        exp_q.delete();
        add_pkt({48'h0, d1}, NB, c1, 1'b0);
        add_ones(GB);
        add_pkt({48'h0, d2}, NB, c2, 1'b0);
        add_ones(4);
        cap.delete();
        rdy  = 0;
        bsy  = 0;
        drop = 1'b0;
        b_if.data_in  = d1;
        b_if.ctl_in   = c1;
        b_if.err_in   = 1'b0;
        b_if.in_valid = 1'b1;
        for (int i = 0; i < total + 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                b_if.data_in = d2;
                b_if.ctl_in  = c2;
            end
            if (drop) b_if.in_valid = 1'b0;
            cap.push_back(sout_b);
            if (i < total) begin
                bsy += int'(busy_b);
                if (b_if.in_ready === 1'b1) begin
                    rdy++;
                    drop = 1'b1;
                end
            end
        end
        b_if.in_valid = 1'b0;
        dd = first_diff();
        tests++;
        if (dd != -1) begin
            fails++;
            $display("FAIL b2b_stream: bit %0d got %b want %b",
                     dd, cap[dd], exp_q[dd]);
        end
        tests++;
        if ({cap[PKT_B], cap[PKT_B+1], cap[PKT_B+2], cap[PKT_B+3]} !== 4'b1110) begin
            fails++;
            $display("FAIL b2b_gap: got %b%b%b%b want 1110",
                     cap[PKT_B], cap[PKT_B+1], cap[PKT_B+2], cap[PKT_B+3]);
        end
        tests++;
        if (rdy != 1 || bsy != total - 1) begin
            fails++;
            $display("FAIL b2b_ready: rdy=%0d busy=%0d want 1 %0d",
                     rdy, bsy, total - 1);
        end
    endtask

    initial begin
        a_if.data_in  = '0;
        a_if.ctl_in   = '0;
        a_if.err_in   = 1'b0;
        a_if.in_valid = 1'b0;
        b_if.data_in  = '0;
        b_if.ctl_in   = '0;
        b_if.err_in   = 1'b0;
        b_if.in_valid = 1'b0;
        test_reset();
        test_normal();
        test_error();
        test_random();
        test_busy_protect();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

endmodule
